data_cache_wb: RTL
==================

// Module: data_cache_wb
// PURPOSE
//  Parametrised direct-mapped, write-back, write-allocate data cache for the MIPS data path.
//  Sits between the MEM stage (cpu_* port) and main RAM (mem_* port).
//  Line-wide req/ack handshake to RAM, dirty-line eviction, hit/miss performance counters.
// PARAMETERS
//  ADDR_W  32  byte address width
//  SETS    4   number of lines, power of 2, >=2; INDEX_W = log2(SETS)
//  WORDS   4   32-bit words per line, power of 2, >=2; LINE_W = 32*WORDS; OFF_W = log2(WORDS)+2
//  CNT_W   16  width of the performance counters
//  Address split: tag = addr[ADDR_W-1:INDEX_W+OFF_W], index = addr[INDEX_W+OFF_W-1:OFF_W],
//  word = addr[OFF_W-1:2], addr[1:0] ignored. TAG_W = ADDR_W - INDEX_W - OFF_W.
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rstn       in   1       asynchronous, active-low reset
//  cpu_req    in   1       access request, held stable with addr/we/wdata until cpu_ready
//  cpu_we     in   1       1 = store word, 0 = load word
//  cpu_addr   in   ADDR_W  byte address
//  cpu_wdata  in   32      store data
//  cpu_rdata  out  32      load data, valid while cpu_ready=1 and cpu_we=0
//  cpu_ready  out  1       access completes this cycle (combinational)
//  mem_req    out  1       RAM transaction request, registered
//  mem_we     out  1       1 = write-back line, 0 = fill line
//  mem_addr   out  ADDR_W  line-aligned address, low OFF_W bits zero
//  mem_wdata  out  LINE_W  victim line, word 0 in bits [31:0]
//  mem_rdata  in   LINE_W  fill line, sampled when mem_ack=1
//  mem_ack    in   1       one-cycle pulse; completes current mem transaction
//  hit_cnt    out  CNT_W   saturating count of hits
//  miss_cnt   out  CNT_W   saturating count of misses
// BEHAVIOUR
//  Per line: valid, dirty, tag, data. Reset (async) clears all valid and dirty bits.
//  Reset also sets: state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt = 0.
//  Outputs cpu_ready and cpu_rdata are 0 in reset. Data/tag arrays are not cleared.
//  hit = cpu_req & valid[idx] & (tag[idx]==addr tag), evaluated only in IDLE.
//  FSM states: IDLE, WBACK, FILL.
//  IDLE, no req: hold.
//  IDLE, hit: cpu_ready=1 same cycle.
//    Load: cpu_rdata = addressed word.
//    Store: word written and dirty[idx] set at that edge.
//    hit_cnt+1, unless this is the retry completing a miss.
//  IDLE, miss: miss_cnt+1 and latch the victim address.
//    valid & dirty victim -> WBACK: mem_req=1, mem_we=1, mem_addr={old tag,idx,0}, mem_wdata=line.
//    otherwise -> FILL: mem_req=1, mem_we=0, mem_addr={req tag,idx,0}.
//  WBACK on mem_ack: dirty[idx]=0; -> FILL. mem_req stays 1 with new we/addr.
//  FILL on mem_ack: line=mem_rdata, tag written, valid=1, dirty=0; mem_req=0; -> IDLE.
//    The held request then hits next cycle (retry, not counted as hit).
//  Latency: hit 0 wait cycles; clean miss = ack delay + 2 cycles; dirty miss adds the write-back handshake.
//  mem_* outputs are stable while mem_req=1. mem_ack while mem_req=0 is ignored.
//  cpu_ready is never 1 outside IDLE. cpu_req changing mid-miss is illegal (undefined result).
//  Counters saturate at all-ones, no wrap.
//  Reset mid-miss aborts the transaction; mem_req drops asynchronously.
//  A later mem_ack is ignored. A partially completed write-back is lost (line invalidated).
// TESTING
//  1. Reset; load 0x40 -> miss, FILL mem_addr=0x40, ack with line {D,C,B,A}
//     -> cpu_rdata=A, hit_cnt=0, miss_cnt=1.
//  2. Load 0x44 after test 1 -> cpu_ready in the same cycle, rdata=B, no mem_req, hit_cnt=1.
//  3. Store 0x48<=0x1234, then load 0x80 (same index, new tag)
//     -> WBACK at 0x40 with word2=0x1234, then FILL at 0x80.
//  4. Clean miss to an index holding clean data -> FILL only, mem_we never 1.
//  5. Assert rstn low during FILL with mem_req=1 -> mem_req=0 immediately.
//     A late mem_ack is ignored; next load of 0x40 misses.
//  6. Force hit_cnt to all-ones via 2^CNT_W hits (CNT_W=4 build) -> stays 15.

Source files
------------

// File: rtl/data_cache_wb.sv
// data_cache_wb: direct-mapped write-back, write-allocate data cache with line-wide RAM handshake
module data_cache_wb #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 4,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [32*WORDS-1:0]   mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int WORD_W  = $clog2(WORDS);
    localparam int OFF_W   = WORD_W + 2;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int LINE_W  = 32 * WORDS;

    typedef enum logic [1:0] {IDLE, WBACK, FILL} state_t;
    state_t state, state_n;

    logic [SETS-1:0]    valid, dirty;
    logic [TAG_W-1:0]   tags  [SETS];
    logic [LINE_W-1:0]  lines [SETS];
    logic               retry;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] idx;
    logic [WORD_W-1:0]  word;
    logic               hit, miss, victim_dirty, fill_done, unused_ok;
    logic               mem_req_n, mem_we_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [LINE_W-1:0]  mem_wdata_n;

    assign tag          = cpu_addr[ADDR_W-1 -: TAG_W];
    assign idx          = cpu_addr[OFF_W +: INDEX_W];
    assign word         = cpu_addr[2 +: WORD_W];
    assign unused_ok    = ^cpu_addr[1:0];
    assign hit          = state == IDLE && cpu_req && valid[idx] && tags[idx] == tag;
    assign miss         = state == IDLE && cpu_req && !hit;
    assign victim_dirty = valid[idx] && dirty[idx];
    assign fill_done    = state == FILL && mem_ack;
    assign cpu_ready    = hit;
    assign cpu_rdata    = (hit && !cpu_we) ? lines[idx][32*word +: 32] : '0;

    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        case (state)
            IDLE: if (miss) begin
                state_n     = victim_dirty ? WBACK : FILL;
                mem_req_n   = 1'b1;
                mem_we_n    = victim_dirty;
                mem_addr_n  = {victim_dirty ? tags[idx] : tag, idx, OFF_W'(0)};
                mem_wdata_n = lines[idx];
            end
            WBACK: if (mem_ack) begin
                state_n    = FILL;
                mem_we_n   = 1'b0;
                mem_addr_n = {tag, idx, OFF_W'(0)};
            end
            FILL: if (mem_ack) begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid     <= '0;
            dirty     <= '0;
            retry     <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if (hit && cpu_we)
                dirty[idx] <= 1'b1;
            if ((state == WBACK && mem_ack) || fill_done)
                dirty[idx] <= 1'b0;
            if (fill_done)
                valid[idx] <= 1'b1;
            // the hit that completes a miss is the retry and is not counted
            if (fill_done)
                retry <= 1'b1;
            else if (hit)
                retry <= 1'b0;
            if (hit && !retry && !(&hit_cnt))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (miss && !(&miss_cnt))
                miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (hit && cpu_we)
            lines[idx][32*word +: 32] <= cpu_wdata;
        if (fill_done) begin
            lines[idx] <= mem_rdata;
            tags[idx]  <= tag;
        end
    end
endmodule
